// File: rtl/sd_card_fsm.sv
// sd_card_fsm: card-side SD command responder used as a card emulator for host loopback bring-up.
// Optional macro SD_CARD_CRC_CHECK_EN rejects command frames whose CRC7 failed.
module sd_card_fsm #(
   parameter int unsigned  NCR         = 2,
   parameter logic [15:0]  RCA         = 16'h1234,
   parameter int unsigned  BUSY_ACMD41 = 3,
   parameter logic [19:0]  MAX_ADDR    = 20'hFFFFF,
   parameter logic [119:0] CID         = 120'h0,
   parameter logic [119:0] CSD         = 120'h0
) (
   input  logic         iclk,
   input  logic         irst,
   input  logic         icmd_valid,
   input  logic [5:0]   icmd_index,
   input  logic [31:0]  icmd_arg,
   input  logic         icmd_crc_ok,
   input  logic         idata_done,
   output logic         oresp_valid,
   output logic         oresp_long,
   output logic [119:0] oresp,
   output logic [3:0]   ocard_state,
   output logic         ostart_read,
   output logic         ostart_write,
   output logic         ostop,
   output logic [19:0]  oaddr,
   output logic         obusy
);
   localparam int unsigned WAIT_W = 7;
   localparam int unsigned A41_W  = 8;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0, ST_READY = 4'd1, ST_IDENT = 4'd2, ST_STBY = 4'd3, ST_TRAN = 4'd4,
      ST_DATA  = 4'd5, ST_RCV   = 4'd6, ST_PRG   = 4'd7, ST_INA  = 4'd8
   } state_t;

   state_t              state, cmd_state, final_state;
   logic                app, err_crc, err_ill;
   logic [A41_W-1:0]    a41_cnt;
   logic                pending, pend_long;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [119:0]        pend_resp;

   logic        cmd_seen, crc_drop, take, legal, r1, has_resp, resp_long, app_nxt;
   logic        oor, rd, wr, stp, card_rst, a41_inc, pwr_up, rca_match, in_range;
   logic [19:0] blk;
   logic [31:0] status;
   logic [119:0] resp;
   logic        unused_bits;

   assign unused_bits = ^{icmd_arg[11:8], icmd_crc_ok};
   assign ocard_state = state;

   // Command decode against the registered state; R1 status reflects the post-command state.
   always_comb begin
      blk       = icmd_arg[31:12];
      rca_match = (icmd_arg[31:16] == RCA);
      in_range  = (blk <= MAX_ADDR);
      pwr_up    = (32'(a41_cnt) >= BUSY_ACMD41);
      cmd_seen  = icmd_valid && !pending && (state != ST_INA);
      crc_drop  = 1'b0;
`ifdef SD_CARD_CRC_CHECK_EN
      crc_drop  = cmd_seen && !icmd_crc_ok;
`endif
      take      = cmd_seen && !crc_drop;
      cmd_state = state;
      legal     = 1'b0;
      r1        = 1'b0;
      has_resp  = 1'b0;
      resp_long = 1'b0;
      resp      = '0;
      app_nxt   = 1'b0;
      oor       = 1'b0;
      rd        = 1'b0;
      wr        = 1'b0;
      stp       = 1'b0;
      card_rst  = 1'b0;
      a41_inc   = 1'b0;
      if (take) begin
         case (icmd_index)
            6'd0: begin legal = 1'b1; card_rst = 1'b1; cmd_state = ST_IDLE; end
            6'd8: if (state == ST_IDLE) begin
               legal = 1'b1; has_resp = 1'b1;
               resp  = {82'b0, 6'd8, 20'h0, 4'h1, icmd_arg[7:0]};
            end
            6'd55: begin legal = 1'b1; r1 = 1'b1; app_nxt = rca_match || (state <= ST_IDENT); end
            6'd41: if (app && state == ST_IDLE) begin
               legal = 1'b1; has_resp = 1'b1; a41_inc = 1'b1;
               resp  = {82'b0, 6'h3F, pwr_up, 9'b0, 2'b11, 20'b0};
               cmd_state = pwr_up ? ST_READY : ST_IDLE;
            end
            6'd2: if (state == ST_READY) begin
               legal = 1'b1; has_resp = 1'b1; resp_long = 1'b1; resp = CID; cmd_state = ST_IDENT;
            end
            6'd3: if (state == ST_IDENT) begin
               legal = 1'b1; has_resp = 1'b1; resp = {82'b0, 6'd3, RCA, 16'h0500}; cmd_state = ST_STBY;
            end
            6'd9: if (state == ST_STBY && rca_match) begin
               legal = 1'b1; has_resp = 1'b1; resp_long = 1'b1; resp = CSD;
            end
            6'd7: if (state == ST_STBY && rca_match) begin
               legal = 1'b1; r1 = 1'b1; cmd_state = ST_TRAN;
            end else if (state == ST_TRAN && !rca_match) begin
               legal = 1'b1; r1 = 1'b1; cmd_state = ST_STBY;
            end
            6'd6, 6'd23: if (app && state == ST_TRAN) begin legal = 1'b1; r1 = 1'b1; end
            6'd18, 6'd25: if (state == ST_TRAN) begin
               legal = 1'b1; r1 = 1'b1;
               if (!in_range) oor = 1'b1;
               else if (icmd_index == 6'd18) begin rd = 1'b1; cmd_state = ST_DATA; end
               else begin wr = 1'b1; cmd_state = ST_RCV; end
            end
            6'd12: if (state == ST_DATA || state == ST_RCV) begin
               legal = 1'b1; r1 = 1'b1; stp = 1'b1;
               cmd_state = (state == ST_DATA) ? ST_TRAN : ST_PRG;
            end
            6'd13: if (rca_match && state >= ST_STBY && state <= ST_PRG) begin legal = 1'b1; r1 = 1'b1; end
            6'd15: if (rca_match && state >= ST_STBY && state <= ST_PRG) begin
               legal = 1'b1; cmd_state = ST_INA;
            end
            default: ;
         endcase
      end
      status = {oor, 7'b0, err_crc, err_ill, 9'b0, cmd_state, (cmd_state != ST_PRG), 2'b0, app_nxt, 5'b0};
      if (r1) begin
         has_resp = 1'b1;
         resp     = {82'b0, icmd_index, status};
      end
      // A coincident data-done still completes programming once the command has seen prg.
      final_state = (state == ST_PRG && idata_done && cmd_state == ST_PRG) ? ST_TRAN : cmd_state;
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         state        <= ST_IDLE;
         app          <= 1'b0;
         err_crc      <= 1'b0;
         err_ill      <= 1'b0;
         a41_cnt      <= '0;
         pending      <= 1'b0;
         wait_cnt     <= '0;
         pend_resp    <= '0;
         pend_long    <= 1'b0;
         oresp_valid  <= 1'b0;
         oresp_long   <= 1'b0;
         oresp        <= '0;
         ostart_read  <= 1'b0;
         ostart_write <= 1'b0;
         ostop        <= 1'b0;
         oaddr        <= '0;
         obusy        <= 1'b0;
      end else begin
         state        <= final_state;
         obusy        <= (final_state == ST_PRG);
         ostart_read  <= rd;
         ostart_write <= wr;
         ostop        <= stp;
         oresp_valid  <= 1'b0;
         if (crc_drop) err_crc <= 1'b1;
         if (take) begin
            if (!legal) err_ill <= 1'b1;
            else        app     <= app_nxt;
            if (card_rst || r1) begin
               err_crc <= 1'b0;
               err_ill <= 1'b0;
            end
            if (card_rst)     a41_cnt <= '0;
            else if (a41_inc) a41_cnt <= a41_cnt + 1'b1;
            if (rd || wr) oaddr <= blk;
            if (has_resp) begin
               pending   <= 1'b1;
               wait_cnt  <= WAIT_W'(NCR - 1);
               pend_resp <= resp;
               pend_long <= resp_long;
            end
         end else if (pending) begin
            if (wait_cnt == WAIT_W'(1)) begin
               pending     <= 1'b0;
               oresp_valid <= 1'b1;
               oresp       <= pend_resp;
               oresp_long  <= pend_long;
            end else begin
               wait_cnt <= wait_cnt - 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_sd_card_fsm.sv
// Bench for sd_card_fsm: directed protocol walk plus randomized commands against a behavioural card model.
`timescale 1ns/1ps
module tb_sd_card_fsm;
   localparam int unsigned  NCR  = 2;
   localparam logic [15:0]  RCA  = 16'h1234;
   localparam int           BUSY = 3;
   localparam logic [19:0]  MAXA = 20'h000FF;
   localparam logic [119:0] CIDV = 120'hC1D0_1111_2222_3333_4444_5555_6666_77;
   localparam logic [119:0] CSDV = 120'hC5D0_8888_9999_AAAA_BBBB_CCCC_DDDD_EE;

   logic         iclk = 1'b0;
   logic         irst = 1'b1;
   logic         icmd_valid = 1'b0;
   logic [5:0]   icmd_index = '0;
   logic [31:0]  icmd_arg = '0;
   logic         icmd_crc_ok = 1'b1;
   logic         idata_done = 1'b0;
   logic         oresp_valid, oresp_long, ostart_read, ostart_write, ostop, obusy;
   logic [119:0] oresp;
   logic [3:0]   ocard_state;
   logic [19:0]  oaddr;

   int errors = 0;
   int checks = 0;

   // Behavioural card model
   int          m_state, m_a41;
   bit          m_app, m_crc, m_ill;
   logic [19:0] m_addr;
   logic [119:0] last_resp;

   sd_card_fsm #(.NCR(NCR), .RCA(RCA), .BUSY_ACMD41(BUSY), .MAX_ADDR(MAXA), .CID(CIDV), .CSD(CSDV)) dut (
      .iclk(iclk), .irst(irst), .icmd_valid(icmd_valid), .icmd_index(icmd_index),
      .icmd_arg(icmd_arg), .icmd_crc_ok(icmd_crc_ok), .idata_done(idata_done),
      .oresp_valid(oresp_valid), .oresp_long(oresp_long), .oresp(oresp),
      .ocard_state(ocard_state), .ostart_read(ostart_read), .ostart_write(ostart_write),
      .ostop(ostop), .oaddr(oaddr), .obusy(obusy));

   always #5 iclk = ~iclk;

   task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_a41 = 0; m_app = 0; m_crc = 0; m_ill = 0; m_addr = '0;
   endtask

   task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic crc, input logic done,
                            output logic ev, output logic [119:0] er, output logic el,
                            output logic erd, output logic ewr, output logic est);
      int nxt, old;
      bit ok, r1, oor, newapp, match, pwr;
      logic [31:0] st, ocr;
      ev = 0; er = '0; el = 0; erd = 0; ewr = 0; est = 0;
      if (m_state == 8) return;
      old = m_state;
`ifdef SD_CARD_CRC_CHECK_EN
      if (!crc) begin
         m_crc = 1;
         if (old == 7 && done) m_state = 4;
         return;
      end
`endif
      nxt = m_state; ok = 0; r1 = 0; oor = 0; newapp = 0;
      match = (arg[31:16] == RCA);
      if (idx == 0) begin
         ok = 1; nxt = 0; m_a41 = 0; m_crc = 0; m_ill = 0;
      end else if (idx == 8 && old == 0) begin
         ok = 1; ev = 1; er = {82'b0, 6'd8, 24'h000001, arg[7:0]};
      end else if (idx == 55) begin
         ok = 1; r1 = 1; newapp = match || (old <= 2);
      end else if (idx == 41 && m_app && old == 0) begin
         ok = 1; ev = 1; m_a41++;
         pwr = (m_a41 >= BUSY + 1);
         ocr = 32'h0030_0000 | (pwr ? 32'h8000_0000 : 32'h0);
         er = {82'b0, 6'h3F, ocr};
         if (pwr) nxt = 1;
      end else if (idx == 2 && old == 1) begin
         ok = 1; ev = 1; el = 1; er = CIDV; nxt = 2;
      end else if (idx == 3 && old == 2) begin
         ok = 1; ev = 1; er = {82'b0, 6'd3, RCA, 16'h0500}; nxt = 3;
      end else if (idx == 9 && old == 3 && match) begin
         ok = 1; ev = 1; el = 1; er = CSDV;
      end else if (idx == 7 && ((old == 3 && match) || (old == 4 && !match))) begin
         ok = 1; r1 = 1; nxt = (old == 3) ? 4 : 3;
      end else if ((idx == 6 || idx == 23) && m_app && old == 4) begin
         ok = 1; r1 = 1;
      end else if ((idx == 18 || idx == 25) && old == 4) begin
         ok = 1; r1 = 1;
         if (arg[31:12] > MAXA) oor = 1;
         else begin
            m_addr = arg[31:12];
            if (idx == 18) begin erd = 1; nxt = 5; end
            else begin ewr = 1; nxt = 6; end
         end
      end else if (idx == 12 && (old == 5 || old == 6)) begin
         ok = 1; r1 = 1; est = 1; nxt = (old == 5) ? 4 : 7;
      end else if (idx == 13 && match && old >= 3 && old <= 7) begin
         ok = 1; r1 = 1;
      end else if (idx == 15 && match && old >= 3 && old <= 7) begin
         ok = 1; nxt = 8;
      end
      if (!ok) m_ill = 1;
      else m_app = newapp;
      if (r1) begin
         st = (oor ? 32'h8000_0000 : 32'h0) | (m_crc ? 32'h0080_0000 : 32'h0) |
              (m_ill ? 32'h0040_0000 : 32'h0) | (32'(nxt) << 9) |
              ((nxt != 7) ? 32'h100 : 32'h0) | (m_app ? 32'h20 : 32'h0);
         ev = 1; er = {82'b0, idx, st};
         m_crc = 0; m_ill = 0;
      end
      m_state = nxt;
      if (old == 7 && nxt == 7 && done) m_state = 4;
   endtask

   task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic crc, input logic done);
      logic ev, el, erd, ewr, est;
      logic [119:0] er, got;
      logic gl;
      int seen;
      model_cmd(idx, arg, crc, done, ev, er, el, erd, ewr, est);
      @(negedge iclk);
      icmd_valid = 1; icmd_index = idx; icmd_arg = arg; icmd_crc_ok = crc; idata_done = done;
      @(negedge iclk);
      icmd_valid = 0; idata_done = 0; icmd_crc_ok = 1;
      chk("state", 120'(ocard_state), 120'(m_state));
      chk("strobes", 120'({ostart_read, ostart_write, ostop}), 120'({erd, ewr, est}));
      chk("busy", 120'(obusy), 120'(m_state == 7));
      chk("addr", 120'(oaddr), 120'(m_addr));
      seen = 0; got = '0; gl = 0;
      for (int k = 1; k <= int'(NCR) + 2; k++) begin
         if (k > 1) @(negedge iclk);
         if (k == 2) chk("strobe_width", 120'({ostart_read, ostart_write, ostop}), 120'(0));
         if (oresp_valid === 1'b1 && seen == 0) begin seen = k; got = oresp; gl = oresp_long; end
      end
      chk("ncr_delay", 120'(seen), ev ? 120'(NCR) : 120'(0));
      if (ev) begin
         chk("resp", got, er);
         chk("resp_long", 120'(gl), 120'(el));
         chk("resp_hold", oresp, got);
         last_resp = got;
      end
   endtask

   task automatic pulse_done();
      if (m_state == 7) m_state = 4;
      @(negedge iclk); idata_done = 1;
      @(negedge iclk); idata_done = 0;
      chk("done_state", 120'(ocard_state), 120'(m_state));
      chk("done_busy", 120'(obusy), 120'(m_state == 7));
   endtask

   task automatic do_reset();
      icmd_valid = 0; idata_done = 0; irst = 1;
      repeat (2) @(negedge iclk);
      irst = 0;
      model_reset();
   endtask

   task automatic drop_test();
      logic ev, el, erd, ewr, est;
      logic [119:0] er;
      int pulses = 0;
      model_cmd(6'd13, {RCA, 16'h0}, 1, 0, ev, er, el, erd, ewr, est);
      @(negedge iclk); icmd_valid = 1; icmd_index = 6'd13; icmd_arg = {RCA, 16'h0};
      @(negedge iclk); if (oresp_valid) pulses++;
      icmd_index = 6'd7; icmd_arg = 32'h0;
      @(negedge iclk); if (oresp_valid) pulses++;
      icmd_valid = 0;
      for (int k = 0; k < int'(NCR) + 2; k++) begin
         @(negedge iclk); if (oresp_valid) pulses++;
      end
      chk("drop_pulses", 120'(pulses), 120'(1));
      chk("drop_state", 120'(ocard_state), 120'(m_state));
      chk("drop_resp", oresp, er);
   endtask

   task automatic rst_mid();
      int pulses = 0;
      @(negedge iclk); icmd_valid = 1; icmd_index = 6'd8; icmd_arg = 32'h1AA;
      @(negedge iclk); icmd_valid = 0; irst = 1;
      @(negedge iclk); irst = 0;
      model_reset();
      for (int k = 0; k < int'(NCR) + 3; k++) begin
         @(negedge iclk); if (oresp_valid) pulses++;
      end
      chk("rst_cancel", 120'(pulses), 120'(0));
      chk("rst_state", 120'(ocard_state), 120'(0));
   endtask

   initial begin
      logic [5:0] cmds [14] = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd2, 6'd3, 6'd9, 6'd7, 6'd6, 6'd23, 6'd18, 6'd25, 6'd12, 6'd13};
      logic [5:0] acmds [3] = '{6'd41, 6'd6, 6'd23};
      logic [5:0] idx, prev;
      logic [31:0] arg;
      logic [31:0] match_arg;
      match_arg = {RCA, 16'h0};
      do_reset();
      chk("rst_state0", 120'(ocard_state), 120'(0));
      chk("rst_resp", oresp, 120'(0));
      chk("rst_outs", 120'({oresp_valid, oresp_long, ostart_read, ostart_write, ostop, obusy}), 120'(0));
      chk("rst_addr", 120'(oaddr), 120'(0));

      do_cmd(6'd8, 32'h1AA, 1, 0);
      chk("r7_plan", 120'(last_resp[37:0]), 120'({6'd8, 32'h000001AA}));
      for (int i = 0; i < 4; i++) begin
         do_cmd(6'd55, 32'h0, 1, 0);
         do_cmd(6'd41, 32'h80300000, 1, 0);
         chk("ocr_busy_bit", 120'(last_resp[31]), 120'(i == 3));
      end
      chk("ready_plan", 120'(ocard_state), 120'(1));
      do_cmd(6'd2, 32'h0, 1, 0);
      do_cmd(6'd3, 32'h0, 1, 0);
      chk("r6_plan", 120'(last_resp[31:0]), 120'(32'h12340500));
      do_cmd(6'd9, match_arg, 1, 0);
      do_cmd(6'd7, match_arg, 1, 0);
      do_cmd(6'd18, 32'h00005000, 1, 0);
      chk("r1_data_plan", 120'(last_resp[12:9]), 120'(5));
      do_cmd(6'd12, 32'h0, 1, 0);
      do_cmd(6'd25, 32'h00100000, 1, 0);
      chk("oor_plan", 120'(last_resp[31]), 120'(1));
      do_cmd(6'd13, match_arg, 1, 0);
      chk("oor_clear", 120'(last_resp[31]), 120'(0));
      do_cmd(6'd25, 32'h000FF000, 1, 0);
      do_cmd(6'd12, 32'h0, 1, 0);
      do_cmd(6'd13, match_arg, 1, 1);
      chk("coinc_r1_state", 120'(last_resp[12:9]), 120'(7));
      do_cmd(6'd25, 32'h000FF000, 1, 0);
      do_cmd(6'd12, 32'h0, 1, 0);
      pulse_done();
      do_cmd(6'd8, 32'h1AA, 1, 0);
      do_cmd(6'd13, match_arg, 1, 0);
      chk("illegal_bit", 120'(last_resp[22]), 120'(1));
      do_cmd(6'd55, match_arg, 1, 0);
      do_cmd(6'd23, 32'h8, 1, 0);
      do_cmd(6'd6, 32'h2, 1, 0);
      do_cmd(6'd13, match_arg, 1, 0);
      drop_test();
      do_cmd(6'd13, match_arg, 0, 0);
      do_cmd(6'd13, match_arg, 1, 0);
`ifdef SD_CARD_CRC_CHECK_EN
      chk("crc_bit", 120'(last_resp[23]), 120'(1));
`endif
      do_cmd(6'd15, match_arg, 1, 0);
      do_cmd(6'd0, 32'h0, 1, 0);
      do_cmd(6'd13, match_arg, 1, 0);
      do_reset();
      rst_mid();

      prev = 6'd0;
      for (int i = 0; i < 300; i++) begin
         if (prev == 6'd55 && $urandom_range(1, 0) == 1) idx = acmds[$urandom_range(2, 0)];
         else begin
            idx = cmds[$urandom_range(13, 1)];
            if ($urandom_range(40, 0) == 0) idx = 6'd0;
            if ($urandom_range(25, 0) == 0) idx = 6'd5;
         end
         arg = ($urandom_range(3, 0) != 0) ? {RCA, 16'($urandom)} : 32'($urandom);
         if (idx == 6'd18 || idx == 6'd25) arg = {20'($urandom_range(288, 200)), 12'($urandom)};
         do_cmd(idx, arg, ($urandom_range(9, 0) != 0), ($urandom_range(4, 0) == 0));
         prev = idx;
         if ($urandom_range(7, 0) == 0) pulse_done();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sd_card_fsm.md
# sd_card_fsm

- Card-side command state machine: the responder end of the SD command protocol issued by the host controller FSM.
- Takes decoded 48-bit command frames from the card CMD-line deserializer. Tracks the SD card state (idle…prg), maintains the card status register and selects R1/R1b/R2/R3/R6/R7 response content.
- Hands that content to the card CMD-line serializer a fixed NCR cycles later, and kicks the card-side data path for multi-block read/write.
- Used as a synthesizable card emulator for loopback bring-up of the host controller.

## Interface
- NCR, 2: command-end to response-start delay in iclk cycles; legal 2..64.
- RCA, 16'h1234: relative card address published in R6.
- BUSY_ACMD41, 3: number of ACMD41s answered with OCR[31]=0 before power-up completes.
- MAX_ADDR, 20'hFFFFF: highest legal arg[31:12] for CMD18/CMD25.
- CID, 120'h0 / CSD, 120'h0: R2 payloads.
- iclk  in  1  clock.
- irst  in  1  reset, asynchronous, active-high.
- icmd_valid  in  1  one-cycle pulse, command frame received.
- icmd_index  in  6  command index, valid with icmd_valid.
- icmd_arg  in  32  command argument, valid with icmd_valid.
- icmd_crc_ok  in  1  CRC7 of frame correct, valid with icmd_valid.
- idata_done  in  1  pulse, card data path finished programming.
- oresp_valid  out  1  one-cycle pulse, response content ready.
- oresp_long  out  1  0: 48-bit (oresp[37:0] = {index6, payload32}); 1: R2 (oresp[119:0]).
- oresp  out  120  response content, held until next oresp_valid.
- ocard_state  out  4  SD CURRENT_STATE: 0 idle, 1 ready, 2 ident, 3 stby, 4 tran, 5 data, 6 rcv, 7 prg, 8 ina.
- ostart_read / ostart_write / ostop  out  1  one-cycle data-path strobes.
- oaddr  out  20  latched arg[31:12] of CMD18/CMD25.
- obusy  out  1  DAT0 busy, high while state = prg.

## Operation
- Status register (32b) bits:
  - 31 OUT_OF_RANGE, 23 COM_CRC_ERROR, 22 ILLEGAL_COMMAND: error bits, cleared after being sent in one R1.
  - 12:9 CURRENT_STATE, 8 READY_FOR_DATA (1 except in prg), 5 APP_CMD.
- APP flag:
  - Set by an accepted CMD55 when arg[31:16] = RCA, or any arg in idle/ready/ident.
  - Cleared by the next accepted command.
  - With APP set, indices 41/6/23 decode as ACMDs.
- R1 status payload is taken after the transition, so R1 reports the state after the command.
- Transitions and responses:
  - CMD0 (any state except ina): → idle; APP, error bits and ACMD41 count cleared; no response.
  - CMD8 in idle: R7 = {8, 20'h0, 4'h1, arg[7:0]}.
  - CMD55: R1 with bit 5 = 1.
  - ACMD41 in idle: R3 = {6'h3F, OCR}.
    - OCR[21:20] = 2'b11.
    - OCR[31] = 1 once the count of ACMD41s reaches BUSY_ACMD41 + 1; at that point idle → ready.
  - CMD2 in ready: R2 CID, → ident.
  - CMD3 in ident: R6 = {3, RCA, 16'h0500 status}, → stby.
  - CMD9 in stby, RCA match: R2 CSD.
  - CMD7: stby + RCA match → tran; tran + mismatch → stby; R1.
  - ACMD6 / ACMD23 in tran: R1, no state change.
  - CMD18 in tran: R1.
    - If arg[31:12] > MAX_ADDR: set OUT_OF_RANGE, stay tran.
    - Otherwise → data, latch oaddr, pulse ostart_read.
  - CMD25 in tran: same check; otherwise → rcv, pulse ostart_write.
  - CMD12: data → tran, rcv → prg; R1 plus ostop.
  - idata_done in prg → tran; ignored in all other states.
  - CMD13 with RCA match, in stby..prg: R1.
  - CMD15 with RCA match: → ina, no response. ina ignores everything until irst.
- Any other index, or an index not legal in the current state: no response, set ILLEGAL_COMMAND.

## Timing
- Reset values: ocard_state = 0; oresp = 0; oresp_long = 0.
  - All strobes 0; obusy = 0; oaddr = 0; status = 0; APP = 0.
- Command decoding uses ocard_state as registered in the cycle of icmd_valid.
- State change and data strobes occur on the edge after icmd_valid.
- oresp_valid fires exactly NCR cycles after icmd_valid.
- icmd_valid during a pending NCR wait: dropped, no status change.
- idata_done coincident with icmd_valid in prg: the command sees prg, then state → tran.
- irst mid-wait: the pending response is cancelled.

## Configuration
- SD_CARD_CRC_CHECK_EN:
  - Defined: icmd_valid with icmd_crc_ok = 0 is dropped, sets COM_CRC_ERROR, and sends no response.
  - Undefined: icmd_crc_ok is ignored.

## Test plan
- Reset, CMD8 arg 32'h1AA → after 2 cycles oresp[37:0] = {6'd8, 32'h000001AA}, state 0.
- CMD55 then ACMD41 ×4 (arg 32'h80300000) → OCR[31] = 0, 0, 0, then 1; state 1 after the fourth.
- CMD2, CMD3, CMD9, CMD7 (arg 32'h12340000) → states 2, 3, 3, 4; R6 payload = 32'h12340500.
- CMD18 arg 32'h00005000 → ostart_read, oaddr = 20'h00005, R1[12:9] = 5; CMD12 → ostop, state 4.
- CMD25 with MAX_ADDR = 3 and arg 32'h00004000 → R1 bit 31 = 1, state 4; next CMD13 → bit 31 = 0.
- With the macro defined: CMD13 with crc_ok = 0 → no oresp_valid; next CMD13 → bit 23 = 1.
